// File: rtl/instr_mem_sync.sv
// Registered-read instruction memory with a run-time program port.
// One-cycle fetch latency, stall hold, flush-to-NOP and fault flagging.
module instr_mem_sync #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              stall,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_fault,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  localparam int IW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_INSTR};

  logic [IW-1:0]     ridx;
  logic [IW-1:0]     widx;
  logic              rd_ok;
  logic              wr_ok;
  logic              hit;
  logic [DATA_W-1:0] rd_word;

  function automatic logic addr_ok(
    input logic [ADDR_W-1:0] a
  );
    return (a[1:0] == 2'b00) &&
           (a[ADDR_W-1:IW+2] == '0);
  endfunction

  assign ridx  = req_addr[IW+1:2];
  assign widx  = prog_addr[IW+1:2];
  assign rd_ok = addr_ok(req_addr);
  assign wr_ok = prog_we && addr_ok(prog_addr);
  assign hit   = wr_ok && (widx == ridx);

  // Write-first: a same-edge write to the fetched word wins.
  assign rd_word = hit ? prog_data : mem[ridx];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[widx] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_instr <= NOP_INSTR;
      rsp_addr  <= '0;
      rsp_fault <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
      rsp_instr <= NOP_INSTR;
      rsp_fault <= 1'b0;
    end else if (stall) begin
      rsp_valid <= rsp_valid;
      rsp_instr <= rsp_instr;
      rsp_addr  <= rsp_addr;
      rsp_fault <= rsp_fault;
    end else if (req_valid) begin
      rsp_valid <= 1'b1;
      rsp_addr  <= req_addr;
      rsp_instr <= rd_ok ? rd_word : NOP_INSTR;
      rsp_fault <= !rd_ok;
    end else begin
      rsp_valid <= 1'b0;
      rsp_instr <= NOP_INSTR;
      rsp_fault <= 1'b0;
    end
  end

endmodule
